sigma_delta_dac_feeder: RTL and testbench

//  Sample scheduler in front of sigma_delta_dac. Buffers upstream PCM samples in a small FIFO and

---
 rtl/sigma_delta_pkg.sv | 30 +++
 rtl/sdm_sync_fifo.sv | 88 ++++++++
 rtl/sigma_delta_dac_feeder.sv | 135 +++++++++++++
 tb/tb_sigma_delta_dac_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - shared types and helpers for the sigma-delta DAC feeder
//
// Purpose: feeder FSM state encoding plus mid-scale and drain-step helpers,
// so every instance derives these values from its own parameters.
// Ports: none (package).
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } feeder_state_t;

  localparam int unsigned DEF_DAC_BITLEN = 24;
  localparam int unsigned DEF_RAMP_SHIFT = 8;

  // Offset-binary zero: the code that puts the DAC output at mid-rail.
  function automatic int unsigned dac_mid(input int unsigned bitlen);
    return 32'd1 << (bitlen - 1);
  endfunction

  // Drain step in LSBs per dac_ready strobe.
  function automatic int unsigned dac_step(input int unsigned bitlen, input int unsigned shift);
    return 32'd1 << (bitlen - shift);
  endfunction

  localparam int unsigned DEF_STEP = dac_step(DEF_DAC_BITLEN, DEF_RAMP_SHIFT);

endpackage

// File: rtl/sdm_sync_fifo.sv
// rtl/sdm_sync_fifo.sv - single-clock sample FIFO with registered flags and sync flush
//
// Purpose: first-word-fall-through FIFO; rd_data_o always shows the oldest entry.
// Ports:
//   clk, rst      clock, async active-low reset
//   flush_i       synchronous empty request; wins over push/pop in the same cycle
//   push_i        write request (ignored while full)
//   wr_data_i     write data
//   pop_i         read request (ignored while empty)
//   rd_data_o     oldest stored word
//   full_o        registered full flag
//   empty_o       registered empty flag
//   level_o       registered occupancy
module sdm_sync_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q & ~flush_i;
  assign do_pop  = pop_i & ~empty_q & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == LW'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/sigma_delta_dac_feeder.sv
// rtl/sigma_delta_dac_feeder.sv - sample scheduler feeding a sigma-delta DAC
//
// Purpose: buffers PCM samples, primes to half-full before playback, hands one
// sample to the DAC per dac_ready strobe, counts underruns, and ramps the output
// back to mid-scale when disabled.
// Ports:
//   clk, rst      clock shared with the DAC, async active-low reset
//   enable        1 = play, 0 = drain to mid-scale and idle
//   s_data/s_valid/s_ready  upstream sample stream (push = s_valid & s_ready)
//   dac_ready     one-cycle strobe from the DAC
//   dac_input     registered sample to the DAC
//   fifo_level    FIFO occupancy
//   underrun_cnt  saturating underrun count
//   state         current FSM state
module sigma_delta_dac_feeder
  import sigma_delta_pkg::*;
#(
  parameter int unsigned DAC_BITLEN = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RAMP_SHIFT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DAC_BITLEN-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          dac_ready,
  output logic [DAC_BITLEN-1:0]         dac_input,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_cnt,
  output feeder_state_t                 state
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_BITLEN-1:0] MID  = DAC_BITLEN'(dac_mid(DAC_BITLEN));
  localparam logic [DAC_BITLEN-1:0] STEP = DAC_BITLEN'(dac_step(DAC_BITLEN, RAMP_SHIFT));
  localparam logic [LW-1:0]         HALF = LW'(FIFO_DEPTH / 2);

  feeder_state_t          state_q, state_d;
  logic [DAC_BITLEN-1:0]  dac_q, dac_d;
  logic [15:0]            ucnt_q, ucnt_d;
  logic                   ready_c, pop, flush;
  logic [DAC_BITLEN-1:0]  fifo_rd_data;
  logic                   fifo_full, fifo_empty;
  logic [LW-1:0]          level;

  sdm_sync_fifo #(
    .WIDTH (DAC_BITLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .push_i    (s_valid & ready_c),
    .wr_data_i (s_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  always_comb begin
    state_d = state_q;
    dac_d   = dac_q;
    ucnt_d  = ucnt_q;
    ready_c = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        flush = 1'b1;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        ready_c = ~fifo_full;
        if (!enable) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (level >= HALF) begin
          state_d = RUN;
        end
      end
      RUN: begin
        ready_c = ~fifo_full;
        // Disable wins over a coincident strobe so no extra sample escapes.
        if (!enable) begin
          state_d = DRAIN;
        end else if (dac_ready) begin
          if (!fifo_empty) begin
            pop   = 1'b1;
            dac_d = fifo_rd_data;
          end else if (ucnt_q != 16'hFFFF) begin
            ucnt_d = ucnt_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (dac_q == MID) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (dac_ready) begin
          // Compare the remaining distance rather than subtracting first,
          // so the last step lands on MID without wrapping.
          if (dac_q > MID) begin
            dac_d = ((dac_q - MID) > STEP) ? (dac_q - STEP) : MID;
          end else begin
            dac_d = ((MID - dac_q) > STEP) ? (dac_q + STEP) : MID;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dac_q   <= MID;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dac_q   <= dac_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign s_ready      = ready_c;
  assign dac_input    = dac_q;
  assign fifo_level   = level;
  assign underrun_cnt = ucnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_sigma_delta_dac_feeder.sv
// tb/tb_sigma_delta_dac_feeder.sv - directed self-checking bench for sigma_delta_dac_feeder
module tb_sigma_delta_dac_feeder;
  import sigma_delta_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [23:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          dac_ready;
  logic [23:0]   dac_input;
  logic [4:0]    fifo_level;
  logic [15:0]   underrun_cnt;
  feeder_state_t state;

  int vectors = 0;
  int miscompares = 0;

  sigma_delta_dac_feeder #(
    .DAC_BITLEN (24),
    .FIFO_DEPTH (16),
    .RAMP_SHIFT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .dac_ready    (dac_ready),
    .dac_input    (dac_input),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    dac_ready = 1'b1;
    tick();
    dac_ready = 1'b0;
  endtask

  task automatic push(input logic [23:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [23:0] val;
    logic acc_now;

    rst = 1'b0; enable = 1'b0; s_data = '0; s_valid = 1'b0; dac_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1. reset state
    check("rst_dac", dac_input, 32'h800000);
    check("rst_state", state, IDLE);
    check("rst_s_ready", s_ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ucnt", underrun_cnt, 0);

    // 2. prime with 1..8, then play them out
    enable = 1'b1;
    tick();
    check("prime_state", state, PRIME);
    check("prime_s_ready", s_ready, 1);
    for (int i = 1; i <= 8; i++) push(24'(i));
    check("prime_level", fifo_level, 8);
    check("prime_dac_mid", dac_input, 32'h800000);
    tick();
    check("run_state", state, RUN);
    for (int k = 1; k <= 8; k++) begin
      check("pop_before", dac_input, 32'(k - 1 == 0 ? 32'h800000 : k - 1));
      pulse();
      check("pop_data", dac_input, 32'(k));
      tick();
      check("pop_hold", dac_input, 32'(k));
    end
    check("run_level_empty", fifo_level, 0);

    // 3. underrun
    for (int k = 0; k < 3; k++) begin
      pulse();
      tick();
    end
    check("ur_dac_hold", dac_input, 32'h000008);
    check("ur_cnt", underrun_cnt, 3);
    check("ur_state", state, RUN);

    // 4. fill to full with no strobes
    accepted = 0;
    val = 24'h000100;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1'b1;
      s_data  = val;
      acc_now = s_ready;
      tick();
      if (acc_now) begin
        accepted++;
        val = val + 24'd1;
        if (accepted == 16) check("s_ready_after_full", s_ready, 0);
      end
    end
    s_valid = 1'b0;
    check("full_accepted", accepted, 16);
    check("full_level", fifo_level, 16);
    check("full_s_ready", s_ready, 0);
    for (int j = 0; j < 16; j++) begin
      pulse();
      check("full_pop_order", dac_input, 32'h000100 + 32'(j));
    end
    check("full_drained_level", fifo_level, 0);

    // 5. drain from 0x900000
    push(24'h900000);
    push(24'hAAAAA1);
    push(24'hAAAAA2);
    push(24'hAAAAA3);
    pulse();
    check("drain_start_dac", dac_input, 32'h900000);
    check("drain_start_level", fifo_level, 3);
    enable = 1'b0;
    tick();
    check("drain_state", state, DRAIN);
    for (int k = 1; k <= 16; k++) begin
      pulse();
      check("drain_step", dac_input, 32'h900000 - 32'(k) * 32'h010000);
      if (k == 2) begin
        enable = 1'b1;
        tick();
        check("drain_ignores_enable", state, DRAIN);
        enable = 1'b0;
      end
    end
    check("drain_no_pop_level", fifo_level, 3);
    check("drain_at_mid_state", state, DRAIN);
    tick();
    check("drain_idle_state", state, IDLE);
    check("drain_idle_level", fifo_level, 0);
    check("drain_ucnt_kept", underrun_cnt, 3);

    // 5b. clamped final step from 0x800005
    enable = 1'b1;
    tick();
    push(24'h800005);
    for (int i = 0; i < 7; i++) push(24'h123456);
    tick();
    check("clamp_run_state", state, RUN);
    pulse();
    check("clamp_start", dac_input, 32'h800005);
    enable = 1'b0;
    tick();
    pulse();
    check("clamp_mid", dac_input, 32'h800000);
    tick();
    check("clamp_idle", state, IDLE);

    // 6. async reset mid-RUN
    enable = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) push(24'h00C000 + 24'(i));
    tick();
    pulse(); pulse(); pulse();
    check("ar_level_pre", fifo_level, 5);
    check("ar_dac_pre", dac_input, 32'h00C003);
    #2;
    rst = 1'b0;
    #1;
    check("ar_dac", dac_input, 32'h800000);
    check("ar_state", state, IDLE);
    check("ar_level", fifo_level, 0);
    check("ar_ucnt", underrun_cnt, 0);
    enable = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("ar_release_state", state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
